// File: rtl/wb_lbus_bridge.sv
// Wishbone-classic slave to localbus bridge: one decoded address window,
// single-cycle localbus strobes, fixed-latency read capture, error on misses.
module wb_lbus_bridge #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h0300_0000,
  parameter int unsigned ADDR_SPAN  = 256,
  parameter int unsigned LB_ADDR_W  = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [31:0]           adr_i,
  input  logic [DATA_W-1:0]     dat_i,
  output logic [DATA_W-1:0]     dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  lb_wr_o,
  output logic                  lb_rd_o,
  output logic [LB_ADDR_W-1:0]  lb_addr_o,
  output logic [DATA_W-1:0]     lb_wdata_o,
  output logic [DATA_W/8-1:0]   lb_be_o,
  input  logic [DATA_W-1:0]     lb_rdata_i
);

  // Parameter sanity checks, resolved at elaboration.
  if (DATA_W % 8 != 0) begin : g_chk_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (ADDR_SPAN != (1 << LB_ADDR_W)) begin : g_chk_span
    $error("ADDR_SPAN must equal 2**LB_ADDR_W");
  end
  if ((RD_LATENCY < 1) || (RD_LATENCY > 15)) begin : g_chk_lat
    $error("RD_LATENCY must be in 1..15");
  end
  if ((ADDR_BASE & 32'(ADDR_SPAN - 1)) != 32'd0) begin : g_chk_align
    $error("ADDR_BASE must be aligned to ADDR_SPAN");
  end

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_DONE,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   ack_d, err_d, wr_d, rd_d;
  logic [LB_ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]      wdata_d, dat_d;
  logic [DATA_W/8-1:0]    be_d;
  logic                   req, in_win;

  assign req    = cyc_i & stb_i;
  assign in_win = (adr_i[31:LB_ADDR_W] == ADDR_BASE[31:LB_ADDR_W]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = lb_addr_o;
    wdata_d = lb_wdata_o;
    be_d    = lb_be_o;
    dat_d   = dat_o;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (!in_win) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (we_i) begin
            addr_d  = adr_i[LB_ADDR_W-1:0];
            wdata_d = dat_i;
            be_d    = sel_i;
            wr_d    = 1'b1;
            state_d = WR_DONE;
          end else begin
            addr_d  = adr_i[LB_ADDR_W-1:0];
            rd_d    = 1'b1;
            cnt_d   = 4'(RD_LATENCY);
            state_d = RD_WAIT;
          end
        end
      end

      // Counter is loaded with RD_LATENCY and sampled at zero, so the capture
      // edge lands RD_LATENCY cycles after the cycle carrying lb_rd_o.
      RD_WAIT: begin
        if (!cyc_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          dat_d   = lb_rdata_i;
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WR_DONE: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else begin
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      lb_wr_o    <= 1'b0;
      lb_rd_o    <= 1'b0;
      lb_addr_o  <= '0;
      lb_wdata_o <= '0;
      lb_be_o    <= '0;
      dat_o      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_o      <= ack_d;
      err_o      <= err_d;
      lb_wr_o    <= wr_d;
      lb_rd_o    <= rd_d;
      lb_addr_o  <= addr_d;
      lb_wdata_o <= wdata_d;
      lb_be_o    <= be_d;
      dat_o      <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_lbus_bridge.sv
// Self-checking bench for wb_lbus_bridge: vector table, random transactions
// against a transaction-level model, and hand-written multi-cycle sequences.
module tb_wb_lbus_bridge;

  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 3;
  localparam int unsigned SPAN = 256;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk, rst, cyc, stb, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i, dat_o, lb_wdata_o, lb_rdata_i;
  logic        ack_o, err_o, lb_wr_o, lb_rd_o;
  logic [7:0]  lb_addr_o;
  logic [3:0]  lb_be_o;

  wb_lbus_bridge #(
    .DATA_W(DW), .ADDR_BASE(BASE), .ADDR_SPAN(SPAN), .LB_ADDR_W(8), .RD_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .err_o(err_o), .lb_wr_o(lb_wr_o), .lb_rd_o(lb_rd_o),
    .lb_addr_o(lb_addr_o), .lb_wdata_o(lb_wdata_o), .lb_be_o(lb_be_o),
    .lb_rdata_i(lb_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Model of the externally visible hold registers.
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_dat;
  logic [3:0]  m_be;

  // Per-transaction observations (offsets in cycles after T0).
  int wr_n, rd_n, ack_n, err_n, wr_at, rd_at, ack_at, err_at, clash;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata, o_dat;
  logic [3:0]  o_be;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        exp_err;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_dat = '0; m_be = '0;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata,
                         input int drop_k, input int rst_k);
    wr_n = 0; rd_n = 0; ack_n = 0; err_n = 0; clash = 0;
    wr_at = -1; rd_at = -1; ack_at = -1; err_at = -1;
    o_addr = '0; o_wdata = '0; o_dat = '0; o_be = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    lb_rdata_i = ~rdata;
    for (int k = 1; k <= int'(LAT) + 5; k++) begin
      @(negedge clk);
      if (lb_wr_o) begin wr_n++; wr_at = k; o_addr = lb_addr_o; o_wdata = lb_wdata_o; o_be = lb_be_o; end
      if (lb_rd_o) begin rd_n++; rd_at = k; o_addr = lb_addr_o; end
      if (ack_o)   begin ack_n++; ack_at = k; o_dat = dat_o; end
      if (err_o)   begin err_n++; err_at = k; end
      if ((ack_o && err_o) || (lb_wr_o && lb_rd_o)) clash++;
      // Read data is valid only for the cycle that ends on the capture edge.
      lb_rdata_i = (k == int'(LAT) + 1) ? rdata : ~rdata;
      if (ack_o || err_o || k == drop_k || k == rst_k) begin cyc = 1'b0; stb = 1'b0; end
      rst = (k == rst_k);
      we_i = 1'($urandom); adr_i = $urandom; dat_i = $urandom; sel_i = 4'($urandom);
    end
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
  endtask

  task automatic check_holds(input string tag);
    chk({tag, ".clash"},      32'(clash), 32'd0);
    chk({tag, ".lb_addr_o"},  32'(lb_addr_o), 32'(m_addr));
    chk({tag, ".lb_wdata_o"}, lb_wdata_o, m_wdata);
    chk({tag, ".lb_be_o"},    32'(lb_be_o), 32'(m_be));
    chk({tag, ".dat_o"},      dat_o, m_dat);
  endtask

  task automatic check_normal(input string tag, input logic we, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [31:0] rdata,
                              input logic exp_err, input logic [7:0] exp_addr);
    if (exp_err) begin
      chk({tag, ".err_n"},  32'(err_n), 32'd1);
      chk({tag, ".err_at"}, 32'(err_at), 32'd1);
      chk({tag, ".ack_n"},  32'(ack_n), 32'd0);
      chk({tag, ".lb_n"},   32'(wr_n + rd_n), 32'd0);
    end else if (we) begin
      chk({tag, ".wr_n"},   32'(wr_n), 32'd1);
      chk({tag, ".wr_at"},  32'(wr_at), 32'd1);
      chk({tag, ".rd_n"},   32'(rd_n), 32'd0);
      chk({tag, ".err_n"},  32'(err_n), 32'd0);
      chk({tag, ".ack_n"},  32'(ack_n), 32'd1);
      chk({tag, ".ack_at"}, 32'(ack_at), 32'd2);
      chk({tag, ".wr_addr"}, 32'(o_addr), 32'(exp_addr));
      chk({tag, ".wr_data"}, o_wdata, dat);
      chk({tag, ".wr_be"},   32'(o_be), 32'(sel));
      m_addr = exp_addr; m_wdata = dat; m_be = sel;
    end else begin
      chk({tag, ".rd_n"},   32'(rd_n), 32'd1);
      chk({tag, ".rd_at"},  32'(rd_at), 32'd1);
      chk({tag, ".wr_n"},   32'(wr_n), 32'd0);
      chk({tag, ".err_n"},  32'(err_n), 32'd0);
      chk({tag, ".ack_n"},  32'(ack_n), 32'd1);
      chk({tag, ".ack_at"}, 32'(ack_at), 32'(LAT + 2));
      chk({tag, ".rd_addr"}, 32'(o_addr), 32'(exp_addr));
      chk({tag, ".ack_dat"}, o_dat, rdata);
      m_addr = exp_addr; m_dat = rdata;
    end
    check_holds(tag);
  endtask

  initial begin
    int strobes;
    int exp_wr[$], exp_ack[$], got_wr[$], got_ack[$];
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we_i = 1'b0; sel_i = '0;
    adr_i = '0; dat_i = '0; lb_rdata_i = '0;
    model_reset();

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.ack", 32'(ack_o), 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.wr",  32'(lb_wr_o), 32'd0);
    chk("rst.rd",  32'(lb_rd_o), 32'd0);
    check_holds("rst");
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_o || err_o || lb_wr_o || lb_rd_o) strobes++;
    end
    chk("idle.strobes", 32'(strobes), 32'd0);

    // Vector table.
    vecs[0] = '{1'b1, 32'h0300_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0, 8'h10};
    vecs[1] = '{1'b0, 32'h0300_00FC, 32'h0,         4'hF, 32'h1234_5678,  1'b0, 8'hFC};
    vecs[2] = '{1'b1, 32'h02FF_FFFF, 32'h1111_2222, 4'hF, 32'h0,          1'b1, 8'h00};
    vecs[3] = '{1'b0, 32'h0300_0100, 32'h0,         4'hF, 32'hCAFE_F00D,  1'b1, 8'h00};
    vecs[4] = '{1'b1, 32'h0300_00FF, 32'hA5A5_5A5A, 4'h8, 32'h0,          1'b0, 8'hFF};
    vecs[5] = '{1'b0, 32'h0300_0000, 32'h0,         4'hF, 32'h0BAD_C0DE,  1'b0, 8'h00};
    vecs[6] = '{1'b0, 32'h0300_00FF, 32'h0,         4'h1, 32'h8765_4321,  1'b0, 8'hFF};
    vecs[7] = '{1'b1, 32'h0300_0000, 32'h0F0F_F0F0, 4'h5, 32'h0,          1'b0, 8'h00};
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].rdata, -1, -1);
      check_normal($sformatf("vec%0d", i), vecs[i].we, vecs[i].dat, vecs[i].sel,
                   vecs[i].rdata, vecs[i].exp_err, vecs[i].exp_addr);
    end

    // Random transactions against the window model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] adr, dat, rdata;
      logic        we, miss;
      logic [3:0]  sel;
      case ($urandom_range(0, 3))
        0:       adr = BASE + 32'($urandom_range(0, SPAN - 1));
        1:       adr = BASE - 32'd1 - 32'($urandom_range(0, 3));
        2:       adr = BASE + SPAN + 32'($urandom_range(0, 3));
        default: adr = $urandom;
      endcase
      we = 1'($urandom); dat = $urandom; sel = 4'($urandom); rdata = $urandom;
      miss = !((adr >= BASE) && (adr <= BASE + SPAN - 1));
      run_txn(we, adr, dat, sel, rdata, -1, -1);
      check_normal($sformatf("rnd%0d", i), we, dat, sel, rdata, miss, 8'(adr - BASE));
    end

    // Read aborted by cyc_i dropping in T0+2.
    run_txn(1'b0, BASE + 32'h08, 32'h0, 4'hF, 32'hAAAA_5555, 2, -1);
    chk("abort_rd.rd_n",  32'(rd_n), 32'd1);
    chk("abort_rd.rd_at", 32'(rd_at), 32'd1);
    chk("abort_rd.ack_n", 32'(ack_n), 32'd0);
    chk("abort_rd.err_n", 32'(err_n), 32'd0);
    m_addr = 8'h08;
    check_holds("abort_rd");

    // Write aborted in WR_DONE.
    run_txn(1'b1, BASE + 32'h30, 32'h7777_8888, 4'hC, 32'h0, 1, -1);
    chk("abort_wr.wr_n",  32'(wr_n), 32'd1);
    chk("abort_wr.ack_n", 32'(ack_n), 32'd0);
    m_addr = 8'h30; m_wdata = 32'h7777_8888; m_be = 4'hC;
    check_holds("abort_wr");

    // Reset asserted in T0+1 of a write.
    run_txn(1'b1, BASE + 32'h20, 32'h55AA_33CC, 4'h3, 32'h0, -1, 1);
    chk("rst_wr.wr_n",  32'(wr_n), 32'd1);
    chk("rst_wr.ack_n", 32'(ack_n), 32'd0);
    chk("rst_wr.err_n", 32'(err_n), 32'd0);
    model_reset();
    check_holds("rst_wr");

    // Held strobe on a fixed write address for 11 cycles.
    for (int t = 0; t < 11; t += 3) begin
      exp_wr.push_back(t + 1);
      if (t + 1 < 11) exp_ack.push_back(t + 2);
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = BASE + 32'h44; dat_i = 32'h1357_9BDF; sel_i = 4'hF;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (lb_wr_o) got_wr.push_back(k);
      if (ack_o)   got_ack.push_back(k);
      if (k == 11) begin cyc = 1'b0; stb = 1'b0; end
    end
    chk("held.wr_count",  32'(got_wr.size()), 32'(exp_wr.size()));
    chk("held.ack_count", 32'(got_ack.size()), 32'(exp_ack.size()));
    foreach (exp_wr[i])
      chk($sformatf("held.wr%0d_at", i), (i < got_wr.size()) ? 32'(got_wr[i]) : 32'hFFFF_FFFF, 32'(exp_wr[i]));
    foreach (exp_ack[i])
      chk($sformatf("held.ack%0d_at", i), (i < got_ack.size()) ? 32'(got_ack[i]) : 32'hFFFF_FFFF, 32'(exp_ack[i]));
    m_addr = 8'h44; m_wdata = 32'h1357_9BDF; m_be = 4'hF;
    check_holds("held");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
